nca_arb: RTL and testbench

NCA_ARB -- requirements
Module: nca_arb

---
 rtl/nca_pkg.sv | 23 ++
 rtl/nca_rr_pick.sv | 30 +++
 rtl/nca_arb.sv | 98 +++++++++
 tb/tb_nca_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/nca_pkg.sv
// Shared widths, saturation limits and slice helpers for the nca_arb
// time-shared multiplier.
package nca_pkg;
  localparam int DW = 18;
  localparam int PW = 36;
  localparam logic signed [PW-1:0] SAT_MAX = 36'sd131071;
  localparam logic signed [PW-1:0] SAT_MIN = -36'sd131072;

  // Low bit of channel k inside a packed NCH*DW bus.
  function automatic int slice_lo(input int k);
    return k * DW;
  endfunction

  function automatic logic signed [DW-1:0] sat18(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return v[DW-1:0];
    end
  endfunction
endpackage

// File: rtl/nca_rr_pick.sv
// Round-robin pick: first eligible channel searching upward from
// last+1 with wrap-around.
module nca_rr_pick
  import nca_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] elig,
  input  logic [2:0]     last,
  output logic           gnt_valid,
  output logic [2:0]     gnt_idx
);

  logic [7:0] elig8;
  assign elig8 = 8'(elig);

  // Walk from farthest to nearest so the nearest eligible channel is the last write.
  always_comb begin
    int c;
    gnt_valid = 1'b0;
    gnt_idx   = 3'd0;
    for (int i = NCH; i >= 1; i--) begin
      c = int'(last) + i;
      c = (c >= NCH) ? c - NCH : c;
      gnt_idx   = elig8[3'(c)] ? 3'(c) : gnt_idx;
      gnt_valid = gnt_valid | elig8[3'(c)];
    end
  end

endmodule

// File: rtl/nca_arb.sv
// NCH-channel round-robin front end sharing one 18x18 signed multiply,
// followed by arithmetic shift and saturation to 18 bits.
module nca_arb
  import nca_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SHIFT = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*DW-1:0]     datain,
  input  logic [NCH*DW-1:0]     ctrl,
  output logic [NCH-1:0]        ack,
  output logic signed [DW-1:0]  dout,
  output logic [2:0]            dout_ch,
  output logic                  dout_valid
);

  localparam logic [2:0] LAST_RST = 3'(NCH - 1);

  logic [NCH-1:0]       elig;
  logic [2:0]           last_grant;
  logic                 gnt_valid;
  logic [2:0]           gnt_idx;
  logic signed [DW-1:0] d_arr [8];
  logic signed [DW-1:0] c_arr [8];

  logic                 s1_valid;
  logic signed [DW-1:0] s1_a;
  logic signed [DW-1:0] s1_b;
  logic [2:0]           s1_ch;
  logic                 s2_valid;
  logic signed [PW-1:0] s2_p;
  logic [2:0]           s2_ch;
  logic signed [PW-1:0] shifted;

  // A channel already acked this cycle is still showing the request it just had served.
  assign elig    = req & ~ack;
  assign shifted = s2_p >>> SHIFT;

  for (genvar k = 0; k < 8; k++) begin : g_unpack
    if (k < NCH) begin : g_ch
      assign d_arr[k] = datain[slice_lo(k) +: DW];
      assign c_arr[k] = ctrl[slice_lo(k) +: DW];
    end else begin : g_pad
      assign d_arr[k] = 18'sd0;
      assign c_arr[k] = 18'sd0;
    end
  end

  nca_rr_pick #(.NCH(NCH)) u_pick (
    .elig      (elig),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_RST;
      ack        <= '0;
      s1_valid   <= 1'b0;
      s1_a       <= 18'sd0;
      s1_b       <= 18'sd0;
      s1_ch      <= 3'd0;
      s2_valid   <= 1'b0;
      s2_p       <= 36'sd0;
      s2_ch      <= 3'd0;
      dout_valid <= 1'b0;
      dout       <= 18'sd0;
      dout_ch    <= 3'd0;
    end else begin
      s1_valid <= gnt_valid;
      ack      <= gnt_valid ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
      if (gnt_valid) begin
        last_grant <= gnt_idx;
        s1_a       <= d_arr[gnt_idx];
        s1_b       <= c_arr[gnt_idx];
        s1_ch      <= gnt_idx;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p  <= PW'(s1_a) * PW'(s1_b);
        s2_ch <= s1_ch;
      end

      // Outputs hold their last result while no new one arrives.
      dout_valid <= s2_valid;
      if (s2_valid) begin
        dout    <= sat18(shifted);
        dout_ch <= s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_nca_arb.sv
// Directed bench for nca_arb: single request, round-robin with saturation
// and truncation corners, mid-flight reset, and a dropped request.
module tb_nca_arb;
  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [71:0]   datain;
  logic [71:0]   ctrl;
  logic [3:0]    ack;
  logic signed [17:0] dout;
  logic [2:0]    dout_ch;
  logic          dout_valid;

  int tests = 0;
  int fails = 0;

  int exp_rr [4] = '{131071, -131071, -1, 0};

  nca_arb #(.NCH(NCH), .SHIFT(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .datain     (datain),
    .ctrl       (ctrl),
    .ack        (ack),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int k, input int d, input int c);
    datain = (datain & ~(72'h3ffff << (k * 18))) | (72'(18'(d)) << (k * 18));
    ctrl   = (ctrl   & ~(72'h3ffff << (k * 18))) | (72'(18'(c)) << (k * 18));
  endtask

  initial begin
    reset  = 1'b1;
    req    = 4'b0000;
    datain = 72'd0;
    ctrl   = 72'd0;
    tick(); tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'($signed(dout)), 32'sd0);
    chk("rst_ch", 32'(dout_ch), 32'd0);
    reset = 1'b0;
    tick();

    // Single request on ch2: 1000 * 0.5 -> 500
    set_ops(2, 1000, 65536);
    req = 4'b0100;
    tick();
    chk("single_ack", 32'(ack), 32'd4);
    chk("single_v0", 32'(dout_valid), 32'd0);
    req = 4'b0000;
    tick();
    chk("single_ack_pulse", 32'(ack), 32'd0);
    chk("single_v1", 32'(dout_valid), 32'd0);
    tick();
    chk("single_valid", 32'(dout_valid), 32'd1);
    chk("single_dout", 32'($signed(dout)), 32'sd500);
    chk("single_ch", 32'(dout_ch), 32'd2);
    tick();
    chk("hold_valid", 32'(dout_valid), 32'd0);
    chk("hold_dout", 32'($signed(dout)), 32'sd500);
    chk("hold_ch", 32'(dout_ch), 32'd2);

    // Fresh reset so ch0 leads; saturation and truncation corners on ch0..ch3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ops(0, -131072, -131072);
    set_ops(1, 131071, -131072);
    set_ops(2, -1, 1);
    set_ops(3, 1, 1);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_ack%0d", i), 32'(ack), 32'(4'b0001 << (i % 4)));
      if (i >= 2) begin
        chk($sformatf("rr_valid%0d", i), 32'(dout_valid), 32'd1);
        chk($sformatf("rr_ch%0d", i), 32'(dout_ch), 32'((i - 2) % 4));
        chk($sformatf("rr_dout%0d", i), 32'($signed(dout)), exp_rr[(i - 2) % 4]);
      end else begin
        chk($sformatf("rr_fill%0d", i), 32'(dout_valid), 32'd0);
      end
    end

    // Reset with results in flight, requests held throughout
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_dout", 32'($signed(dout)), 32'sd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ack0", 32'(ack), 32'd1);
    chk("post_rst_nov0", 32'(dout_valid), 32'd0);
    tick();
    chk("post_rst_ack1", 32'(ack), 32'd2);
    chk("post_rst_nov1", 32'(dout_valid), 32'd0);
    req = 4'b0000;
    tick();
    chk("post_rst_ack_idle", 32'(ack), 32'd0);
    chk("post_rst_valid0", 32'(dout_valid), 32'd1);
    chk("post_rst_ch0", 32'(dout_ch), 32'd0);
    chk("post_rst_dout0", 32'($signed(dout)), 32'sd131071);
    tick();
    chk("post_rst_ch1", 32'(dout_ch), 32'd1);
    chk("post_rst_dout1", 32'($signed(dout)), -32'sd131071);
    tick();
    chk("drain_valid", 32'(dout_valid), 32'd0);

    // Dropped request on ch1: 301 * -65536 / 2^17 = -150.5 floors to -151
    set_ops(1, 301, -65536);
    req = 4'b0010;
    tick();
    chk("drop_ack", 32'(ack), 32'd2);
    req = 4'b0000;
    set_ops(1, 0, 0);
    tick();
    chk("drop_ack_gone", 32'(ack), 32'd0);
    tick();
    chk("drop_valid", 32'(dout_valid), 32'd1);
    chk("drop_ch", 32'(dout_ch), 32'd1);
    chk("drop_dout", 32'($signed(dout)), -32'sd151);
    tick();
    chk("drop_end", 32'(dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
